// File: rtl/dc_fifo_pkg.sv
// Shared definitions for the one-hot FIFO controller: pointer reset position,
// occupancy state encoding and the occupancy counter width helper.
package dc_fifo_pkg;

   localparam int unsigned PTR_RESET_IDX = 0;

   typedef enum logic [1:0] {
      OCC_EMPTY   = 2'b00,
      OCC_PARTIAL = 2'b01,
      OCC_FULL    = 2'b10
   } occ_state_e;

   // Occupancy runs 0..depth inclusive, hence one bit more than the index width.
   function automatic int unsigned count_width(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/dc_onehot_fifo_ctrl_chk.sv
// Property checker for the one-hot FIFO controller: pointers stay one-hot and
// handshake flags agree with the occupancy count.
module dc_onehot_fifo_ctrl_chk #(
   parameter int unsigned DEPTH = 8
) (
   input logic                     clk,
   input logic                     rst,
   input logic [DEPTH-1:0]         write_pointer,
   input logic [DEPTH-1:0]         read_pointer,
   input logic [$clog2(DEPTH):0]   count,
   input logic                     in_ready,
   input logic                     out_valid
);

   localparam logic [$clog2(DEPTH):0] CNT_FULL = ($clog2(DEPTH)+1)'(DEPTH);
   localparam logic [$clog2(DEPTH):0] CNT_ZERO = {($clog2(DEPTH)+1){1'b0}};

   wp_onehot_a: assert property (@(posedge clk) disable iff (rst) $onehot(write_pointer));
   rp_onehot_a: assert property (@(posedge clk) disable iff (rst) $onehot(read_pointer));
   cnt_range_a: assert property (@(posedge clk) disable iff (rst) count <= CNT_FULL);
   ready_a:     assert property (@(posedge clk) disable iff (rst) in_ready == (count != CNT_FULL));
   valid_a:     assert property (@(posedge clk) disable iff (rst) out_valid == (count != CNT_ZERO));

endmodule

// File: rtl/oh_ring_ptr.sv
// One-hot ring pointer: rotates left by one slot when advanced, returns to the
// reset slot on reset or clear.
module oh_ring_ptr
   import dc_fifo_pkg::*;
#(
   parameter int unsigned DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             advance,
   output logic [DEPTH-1:0] ptr
);

   localparam logic [DEPTH-1:0] PTR_INIT = {{(DEPTH-1){1'b0}}, 1'b1} << PTR_RESET_IDX;

   logic [DEPTH-1:0] ptr_r;

   // pointer register: clear wins over advance, top bit wraps to bit 0
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         ptr_r <= PTR_INIT;
      end else if (advance) begin
         ptr_r <= {ptr_r[DEPTH-2:0], ptr_r[DEPTH-1]};
      end else begin
         ptr_r <= ptr_r;
      end
   end

   assign ptr = ptr_r;

endmodule

// File: rtl/dc_onehot_fifo_ctrl.sv
// Storage-less FIFO controller driving a one-hot addressed buffer: write strobe,
// one-hot read/write slot selects, occupancy count and ready/valid handshake.
module dc_onehot_fifo_ctrl
   import dc_fifo_pkg::*;
#(
   parameter int unsigned BUFFER_DEPTH       = 8,
   parameter int unsigned ALMOST_FULL_THRESH = BUFFER_DEPTH - 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          flush,
   input  logic                          in_valid,
   output logic                          in_ready,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic                          write_enable,
   output logic [BUFFER_DEPTH-1:0]       write_pointer,
   output logic [BUFFER_DEPTH-1:0]       read_pointer,
   output logic [$clog2(BUFFER_DEPTH):0] count,
   output logic                          almost_full
);

   localparam int unsigned CW = count_width(BUFFER_DEPTH);
   localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
   localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0] CNT_FULL = CW'(BUFFER_DEPTH);
   localparam logic [CW-1:0] CNT_AF   = CW'(ALMOST_FULL_THRESH);

   occ_state_e    state_r;
   occ_state_e    state_next_s;
   logic [CW-1:0] count_r;
   logic [CW-1:0] count_next_s;
   logic          in_ready_r;
   logic          out_valid_r;
   logic          almost_full_r;
   logic          push_s;
   logic          pop_s;

   // Handshakes qualify only on registered occupancy, so a full buffer never
   // accepts a word even when a pop lands in the same cycle.
   assign push_s = in_valid  & (state_r != OCC_FULL)  & ~flush & ~rst;
   assign pop_s  = out_ready & (state_r != OCC_EMPTY) & ~flush & ~rst;

   // next occupancy and the occupancy class it falls into
   always_comb begin
      count_next_s = count_r;
      state_next_s = state_r;
      if (flush) begin
         count_next_s = CNT_ZERO;
      end else if (push_s && !pop_s) begin
         count_next_s = count_r + CNT_ONE;
      end else if (pop_s && !push_s) begin
         count_next_s = count_r - CNT_ONE;
      end else begin
         count_next_s = count_r;
      end
      case (count_next_s)
         CNT_ZERO: state_next_s = OCC_EMPTY;
         CNT_FULL: state_next_s = OCC_FULL;
         default:  state_next_s = OCC_PARTIAL;
      endcase
   end

   // occupancy FSM with registered status flags
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r       <= OCC_EMPTY;
         count_r       <= CNT_ZERO;
         in_ready_r    <= 1'b1;
         out_valid_r   <= 1'b0;
         almost_full_r <= 1'b0;
      end else begin
         state_r       <= state_next_s;
         count_r       <= count_next_s;
         in_ready_r    <= (state_next_s != OCC_FULL);
         out_valid_r   <= (state_next_s != OCC_EMPTY);
         almost_full_r <= (count_next_s >= CNT_AF);
      end
   end

   oh_ring_ptr #(
      .DEPTH   (BUFFER_DEPTH)
   ) u_wr_ptr (
      .clk     (clk),
      .rst     (rst),
      .clear   (flush),
      .advance (push_s),
      .ptr     (write_pointer)
   );

   oh_ring_ptr #(
      .DEPTH   (BUFFER_DEPTH)
   ) u_rd_ptr (
      .clk     (clk),
      .rst     (rst),
      .clear   (flush),
      .advance (pop_s),
      .ptr     (read_pointer)
   );

   // The buffer captures its data on this strobe at the same edge.
   assign write_enable = push_s;
   assign in_ready     = in_ready_r;
   assign out_valid    = out_valid_r;
   assign count        = count_r;
   assign almost_full  = almost_full_r;

endmodule

// File: tb/tb_dc_onehot_fifo_ctrl.sv
// Self-checking bench: an external one-hot addressed data buffer, a queue-based
// reference model of occupancy/slots, and a scoreboard checking read-out data.
module tb_dc_onehot_fifo_ctrl;

   localparam int D  = 8;
   localparam int AF = 7;

   logic          clk = 1'b0;
   logic          rst, flush, in_valid, out_ready;
   logic          in_ready, out_valid, write_enable, almost_full;
   logic [D-1:0]  write_pointer, read_pointer;
   logic [3:0]    count;
   logic [15:0]   in_data;

   always #5 clk = ~clk;

   dc_onehot_fifo_ctrl #(.BUFFER_DEPTH(D), .ALMOST_FULL_THRESH(AF)) dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .out_valid(out_valid), .out_ready(out_ready), .write_enable(write_enable),
      .write_pointer(write_pointer), .read_pointer(read_pointer),
      .count(count), .almost_full(almost_full)
   );

   dc_onehot_fifo_ctrl_chk #(.DEPTH(D)) u_chk (
      .clk(clk), .rst(rst), .write_pointer(write_pointer), .read_pointer(read_pointer),
      .count(count), .in_ready(in_ready), .out_valid(out_valid)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int dec(input logic [D-1:0] v);
      for (int i = 0; i < D; i++) if (v[i]) return i;
      return 0;
   endfunction

   // reference model: occupancy as a number, slots as ring indices
   int          cnt_m = 0, widx_m = 0, ridx_m = 0;
   bit          started = 1'b0;
   logic [15:0] sb_q[$];
   logic [15:0] buf_mem [D];
   bit          we_l;
   int          widx_l;
   logic [15:0] wdata_l;

   always @(posedge clk) begin
      if (we_l) buf_mem[widx_l] = wdata_l;
      if (rst || (started && flush)) begin
         started = 1'b1;
         cnt_m = 0; widx_m = 0; ridx_m = 0;
         sb_q.delete();
      end else if (started) begin
         bit push_m, pop_m;
         push_m = in_valid  && (cnt_m < D);
         pop_m  = out_ready && (cnt_m > 0);
         if (push_m) begin
            sb_q.push_back(in_data);
            widx_m = (widx_m + 1) % D;
         end
         if (pop_m) ridx_m = (ridx_m + 1) % D;
         cnt_m = cnt_m + int'(push_m) - int'(pop_m);
      end
   end

   // per-cycle comparison of every controller output against the model
   always @(negedge clk) begin
      we_l = 1'b0;
      if (started) begin
         check("count",         32'(count),         32'(cnt_m));
         check("in_ready",      32'(in_ready),      32'(cnt_m < D));
         check("out_valid",     32'(out_valid),     32'(cnt_m > 0));
         check("almost_full",   32'(almost_full),   32'(cnt_m >= AF));
         check("write_pointer", 32'(write_pointer), 32'(1) << widx_m);
         check("read_pointer",  32'(read_pointer),  32'(1) << ridx_m);
         check("write_enable",  32'(write_enable),
               32'(!rst && !flush && in_valid && (cnt_m < D)));
         we_l    = write_enable;
         widx_l  = dec(write_pointer);
         wdata_l = in_data;
      end
   end

   // scoreboard monitor: each consumed word must be the oldest one pushed
   always @(negedge clk) begin
      if (started && !rst && !flush && out_valid && out_ready) begin
         if (sb_q.size() == 0) begin
            check("pop_when_model_empty", 32'(1), 32'(0));
         end else begin
            logic [15:0] exp_d;
            exp_d = sb_q.pop_front();
            check("read_data", 32'(buf_mem[dec(read_pointer)]), 32'(exp_d));
         end
      end
   end

   task automatic cyc(input bit r, input bit f, input bit v, input bit o);
      rst = r; flush = f; in_valid = v; out_ready = o;
      in_data = 16'($urandom);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int p_in, p_out;
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      repeat (8) cyc(1'b0, 1'b0, 1'b1, 1'b0);   // fill, almost_full at 7
      cyc(1'b0, 1'b0, 1'b1, 1'b0);              // push refused while full
      cyc(1'b0, 1'b0, 1'b1, 1'b1);              // full: pop only, no write
      repeat (8) cyc(1'b0, 1'b0, 1'b0, 1'b1);   // drain
      cyc(1'b0, 1'b0, 1'b1, 1'b0);              // push into empty, no pass-through
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      repeat (2) cyc(1'b0, 1'b0, 1'b1, 1'b0);   // count 3
      repeat (10) cyc(1'b0, 1'b0, 1'b1, 1'b1);  // steady state, pointers wrap
      repeat (2) cyc(1'b0, 1'b0, 1'b1, 1'b0);   // count 5
      cyc(1'b0, 1'b1, 1'b1, 1'b1);              // flush beats push/pop
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      repeat (4) cyc(1'b0, 1'b0, 1'b1, 1'b0);   // count 4
      cyc(1'b1, 1'b1, 1'b0, 1'b0);              // reset together with flush
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      p_in = 50; p_out = 50;
      for (int i = 0; i < 3000; i++) begin
         bit r, f;
         if (i % 300 == 0) begin
            p_in  = $urandom_range(10, 90);
            p_out = $urandom_range(10, 90);
         end
         r = ($urandom_range(0, 199) == 0);
         f = ($urandom_range(0, 39) == 0);
         cyc(r, f, !r && ($urandom_range(0, 99) < p_in), $urandom_range(0, 99) < p_out);
      end
      repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/dc_onehot_fifo_ctrl.md
DC_ONEHOT_FIFO_CTRL -- requirements
Module: dc_onehot_fifo_ctrl

Interface
REQ-001 SHALL have parameter BUFFER_DEPTH, default 8, number of one-hot buffer slots (>=2).
REQ-002 SHALL have parameter ALMOST_FULL_THRESH, default BUFFER_DEPTH-1, occupancy at which almost_full asserts (1..BUFFER_DEPTH).
REQ-003 SHALL use one clock and a synchronous, active-high reset.
REQ-004 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous active-high reset.
REQ-006 SHALL have port flush  input  1  synchronous clear of occupancy and pointers.
REQ-007 SHALL have port in_valid  input  1  upstream offers a word.
REQ-008 SHALL have port in_ready  output  1  controller can accept a word.
REQ-009 SHALL have port out_valid  output  1  word available at read_pointer slot.
REQ-010 SHALL have port out_ready  input  1  downstream consumes the word.
REQ-011 SHALL have port write_enable  output  1  buffer write strobe.
REQ-012 SHALL have port write_pointer  output  BUFFER_DEPTH  one-hot write slot select.
REQ-013 SHALL have port read_pointer  output  BUFFER_DEPTH  one-hot read slot select.
REQ-014 SHALL have port count  output  $clog2(BUFFER_DEPTH)+1  current occupancy.
REQ-015 SHALL have port almost_full  output  1  count >= ALMOST_FULL_THRESH.

Function
REQ-016 SHALL define push = in_valid & in_ready & ~flush; pop = out_valid & out_ready & ~flush.
REQ-017 SHALL drive write_enable = push combinationally; buffer captures write_data at that edge.
REQ-018 SHALL rotate write_pointer left by one bit on the edge after a push; bit BUFFER_DEPTH-1 wraps to bit 0.
REQ-019 SHALL rotate read_pointer identically on pop; pointers SHALL be exactly one-hot at all times.
REQ-020 SHALL update count: +1 on push only, -1 on pop only, unchanged on both or neither.
REQ-021 SHALL drive in_ready = (count != BUFFER_DEPTH); out_valid = (count != 0); both registered-state derived, no combinational path from in_valid or out_ready.
REQ-022 SHALL give write-to-read latency of one cycle: word pushed at edge N is out_valid from cycle N+1.
REQ-023 SHALL not pass through when empty: out_valid stays 0 in the push cycle.
REQ-024 SHALL not accept a push when full even if pop is asserted in the same cycle.
REQ-025 SHALL, when flush=1, set count=0 and both pointers to 1 at next edge; flush overrides push/pop and forces write_enable=0.
REQ-026 SHALL keep occupancy states EMPTY (count 0), PARTIAL, FULL (count BUFFER_DEPTH); transitions only by +/-1 or flush/rst to EMPTY.

Reset
REQ-027 SHALL on rst=1 at a rising edge set write_pointer=read_pointer=1 (bit 0), count=0.
REQ-028 SHALL produce after reset: in_ready=1, out_valid=0, write_enable=0, almost_full=0.
REQ-029 SHALL, on reset mid-operation, discard all occupancy; buffer contents are don't-care.
REQ-030 SHALL give rst priority over flush, push and pop.

Structure
REQ-031 SHALL place pointer reset value constant and count-width function in shared package dc_fifo_pkg.
REQ-032 SHALL implement each pointer as one instance of sub-module oh_ring_ptr (one-hot rotate with enable, clear).
REQ-033 SHALL contain no data storage; data lives in the one-hot-addressed buffer driven by write_enable/pointers.

Verification (BUFFER_DEPTH=8, ALMOST_FULL_THRESH=7)
REQ-034 SHALL cover: rst then 8 pushes, out_ready=0 -> write_pointer 0x01..0x80 then 0x01, count=8, in_ready=0, almost_full from count 7.
REQ-035 SHALL cover: full, in_valid=1 and out_ready=1 same cycle -> no write_enable, count 8->7, read_pointer 0x01->0x02.
REQ-036 SHALL cover: empty, push at edge N -> out_valid=0 in cycle N, 1 in N+1, read_pointer=0x01.
REQ-037 SHALL cover: count=3, push and pop every cycle for 10 cycles -> count stays 3, both pointers wrap past 0x80.
REQ-038 SHALL cover: count=5, flush=1 with in_valid=1 -> write_enable=0, next cycle count=0, pointers=0x01.
REQ-039 SHALL cover: count=4, rst=1 with flush=1 -> count=0, out_valid=0, pointers=0x01; one-hot assertion never fails.
